axis_traffic_gen_chk: RTL and testbench

//  Parametrised AXI4-Stream traffic generator + loopback checker for the 10G eth path; supersedes the fixed-pattern
//  eth test data generator. Sends pkt_num packets of pkt_len bytes in a selectable pattern on tx_axis, regenerates
//  the same stream independently to check rx_axis, counts packets/errors, reports done/pass. Sits on coreclk beside eth_wrap.

---
 rtl/axis_traffic_gen_chk.sv | 193 +++++++++++++++++++
 tb/tb_axis_traffic_gen_chk.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_traffic_gen_chk.sv
// axis_traffic_gen_chk: AXI4-Stream pattern generator with an independent loopback checker and run status
module axis_traffic_gen_chk #(
  parameter int          AXIS_DATA_WIDTH = 64,
  parameter int          LEN_WIDTH       = 16,
  parameter int          CNT_WIDTH       = 32,
  parameter int          IFG_CYCLES      = 4,
  parameter logic [31:0] SEED            = 32'h1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         test_en,
  input  logic [1:0]                   mode,
  input  logic [LEN_WIDTH-1:0]         pkt_len,
  input  logic [CNT_WIDTH-1:0]         pkt_num,
  output logic [AXIS_DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] tx_axis_tkeep,
  output logic                         tx_axis_tvalid,
  output logic                         tx_axis_tlast,
  input  logic                         tx_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
  input  logic                         rx_axis_tvalid,
  input  logic                         rx_axis_tlast,
  output logic                         rx_axis_tready,
  output logic [CNT_WIDTH-1:0]         tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]         rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]         err_cnt,
  output logic                         test_done,
  output logic                         test_pass
);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int B  = W / 8;
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
  function automatic logic [W-1:0] pattern(input logic [1:0] m, input logic [7:0] w, input logic [31:0] s);
    logic [W-1:0] d;
    for (int i = 0; i < B; i++)
      d[8*i +: 8] = m == 2'd2 ? 8'hA5 : m == 2'd1 ? s[8*(i%4) +: 8] : 8'(int'(w) * B + i);
    return d;
  endfunction
  state_t                 state;
  logic                   en_d, fin, chk_act, lost, hold, ff;
  logic [1:0]             mode_r;
  logic [LEN_WIDTH-1:0]   beats_r, tbcnt, rbcnt, len_eff, rem, beats_n;
  logic [LEN_WIDTH:0]     len_sum;
  logic [B-1:0]           last_keep_r, keep_n, e_keep;
  logic [CNT_WIDTH-1:0]   num_r;
  logic [7:0]             tw, rw;
  logic [31:0]            tlfsr, rlfsr;
  logic [GW-1:0]          gap_cnt;
  logic [9:0]             tmo;
  logic [W-1:0]           e_data, m;
  logic                   start, t_last, r_last, tx_fire, rx_fire, done_cond, done_set, mismatch, r_step;
  assign start     = test_en & ~en_d & (state == IDLE || state == DONE);
  assign len_eff   = pkt_len == '0 ? LEN_WIDTH'(B) : pkt_len;
  assign len_sum   = {1'b0, len_eff} + (LEN_WIDTH+1)'(B - 1);
  assign beats_n   = LEN_WIDTH'(len_sum / (LEN_WIDTH+1)'(B));
  assign rem       = len_eff % LEN_WIDTH'(B);
  assign keep_n    = rem == '0 ? '1 : {B{1'b1}} >> (LEN_WIDTH'(B) - rem);
  assign t_last    = tbcnt == beats_r - LEN_WIDTH'(1);
  assign r_last    = rbcnt == beats_r - LEN_WIDTH'(1);
  assign tx_fire   = tx_axis_tvalid & tx_axis_tready;
  assign rx_fire   = rx_axis_tvalid & rx_axis_tready & chk_act;
  assign done_cond = (num_r != '0 && tx_pkt_cnt + CNT_WIDTH'(1) == num_r) || !test_en;
  assign done_set  = state == DONE && !test_done && (rx_pkt_cnt == tx_pkt_cnt || tmo == '1);
  assign tx_axis_tdata = tx_axis_tvalid ? pattern(mode_r, tw, tlfsr) : '0;
  assign tx_axis_tkeep = tx_axis_tvalid ? (t_last ? last_keep_r : '1) : '0;
  assign tx_axis_tlast = tx_axis_tvalid & t_last;
  assign e_data = pattern(mode_r, rw, rlfsr);
  assign e_keep = r_last ? last_keep_r : '1;
  always_comb
    for (int i = 0; i < B; i++) m[8*i +: 8] = {8{e_keep[i]}};
  assign mismatch = (|((rx_axis_tdata ^ e_data) & m)) | (rx_axis_tkeep != e_keep) | (rx_axis_tlast != r_last);
  // While resyncing, the expected stream parks at the start of the next packet until rx tlast
  assign r_step = (chk_act & ff) | (rx_fire & ~hold);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      en_d           <= 1'b0;
      rx_axis_tready <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      mode_r         <= '0;
      beats_r        <= '0;
      last_keep_r    <= '0;
      num_r          <= '0;
      tw             <= '0;
      tlfsr          <= SEED;
      tbcnt          <= '0;
      fin            <= 1'b0;
      gap_cnt        <= '0;
      tmo            <= '0;
      tx_pkt_cnt     <= '0;
      test_done      <= 1'b0;
      test_pass      <= 1'b0;
    end else begin
      en_d           <= test_en;
      rx_axis_tready <= 1'b1;
      if (start) begin
        state          <= SEND;
        tx_axis_tvalid <= 1'b1;
        mode_r         <= mode;
        beats_r        <= beats_n;
        last_keep_r    <= keep_n;
        num_r          <= pkt_num;
        tw             <= '0;
        tlfsr          <= SEED;
        tbcnt          <= '0;
        fin            <= 1'b0;
        tmo            <= '0;
        tx_pkt_cnt     <= '0;
        test_done      <= 1'b0;
        test_pass      <= 1'b0;
      end else begin
        case (state)
          SEND: if (tx_fire) begin
            tw    <= tw + 8'd1;
            tlfsr <= lfsr_step(tlfsr);
            tbcnt <= t_last ? '0 : tbcnt + LEN_WIDTH'(1);
            if (t_last) begin
              tx_pkt_cnt <= tx_pkt_cnt + CNT_WIDTH'(1);
              if (IFG_CYCLES != 0) begin
                state          <= GAP;
                tx_axis_tvalid <= 1'b0;
                gap_cnt        <= '0;
                fin            <= done_cond;
              end else if (done_cond) begin
                state          <= DONE;
                tx_axis_tvalid <= 1'b0;
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
              state          <= fin ? DONE : SEND;
              tx_axis_tvalid <= ~fin;
            end
          end
          DONE: begin
            tmo <= tmo == '1 ? tmo : tmo + 10'd1;
            if (done_set) begin
              test_done <= 1'b1;
              test_pass <= err_cnt == '0 && rx_pkt_cnt == tx_pkt_cnt;
            end
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rw         <= '0;
      rlfsr      <= SEED;
      rbcnt      <= '0;
      lost       <= 1'b0;
      hold       <= 1'b0;
      ff         <= 1'b0;
      chk_act    <= 1'b0;
      rx_pkt_cnt <= '0;
      err_cnt    <= '0;
    end else if (start) begin
      rw         <= '0;
      rlfsr      <= SEED;
      rbcnt      <= '0;
      lost       <= 1'b0;
      hold       <= 1'b0;
      ff         <= 1'b0;
      chk_act    <= 1'b1;
      rx_pkt_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (done_set) chk_act <= 1'b0;
      if (rx_fire & rx_axis_tlast) rx_pkt_cnt <= rx_pkt_cnt + CNT_WIDTH'(1);
      if (rx_fire & ~ff & ~lost & mismatch & (err_cnt != '1)) err_cnt <= err_cnt + CNT_WIDTH'(1);
      if (r_step) begin
        rw    <= rw + 8'd1;
        rlfsr <= lfsr_step(rlfsr);
        rbcnt <= r_last ? '0 : rbcnt + LEN_WIDTH'(1);
      end
      // A short rx packet leaves expected beats owed; fast-forward through them one per cycle
      if (ff) ff <= ~r_last;
      else if (rx_fire & (lost | mismatch)) begin
        lost <= ~rx_axis_tlast;
        hold <= ~rx_axis_tlast & (hold | r_last);
        ff   <= rx_axis_tlast & ~hold & ~r_last;
      end
    end
  end
endmodule

// File: tb/tb_axis_traffic_gen_chk.sv
// tb_axis_traffic_gen_chk: randomized loopback bench with a packet-level reference model
module tb_axis_traffic_gen_chk;
  localparam int B = 8;
  logic        clk = 0, rstn = 0, test_en = 0, tx_tready = 0, junk = 0;
  logic [1:0]  mode = 0;
  logic [15:0] pkt_len = 0;
  logic [31:0] pkt_num = 0;
  logic [63:0] tx_tdata, rx_tdata, kmask, flip = 0;
  logic [7:0]  tx_tkeep;
  logic        tx_tvalid, tx_tlast, rx_tready, test_done, test_pass;
  logic [31:0] tx_pkt_cnt, rx_pkt_cnt, err_cnt;
  logic [63:0] exp_d[$], obs_d[$];
  logic [7:0]  exp_k[$], obs_k[$];
  logic        exp_l[$], obs_l[$];
  int checks = 0, failures = 0, stall_viol = 0;
  bit timed_out;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < B; i++) kmask[8*i +: 8] = {8{tx_tkeep[i]}};
  assign rx_tdata = (tx_tdata ^ flip) | (junk ? ~kmask : 64'h0);
  axis_traffic_gen_chk dut (
    .clk(clk), .rstn(rstn), .test_en(test_en), .mode(mode), .pkt_len(pkt_len), .pkt_num(pkt_num),
    .tx_axis_tdata(tx_tdata), .tx_axis_tkeep(tx_tkeep), .tx_axis_tvalid(tx_tvalid),
    .tx_axis_tlast(tx_tlast), .tx_axis_tready(tx_tready),
    .rx_axis_tdata(rx_tdata), .rx_axis_tkeep(tx_tkeep), .rx_axis_tvalid(tx_tvalid & tx_tready),
    .rx_axis_tlast(tx_tlast), .rx_axis_tready(rx_tready),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .err_cnt(err_cnt),
    .test_done(test_done), .test_pass(test_pass)
  );
  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction
  // Expected beat list for a whole run: word counter and PRBS state run continuously across packets
  task automatic gen_model(input int m, input int len, input int num);
    int le, nb, rem, w;
    logic [31:0] s;
    logic [63:0] d;
    le = len == 0 ? B : len;
    nb = (le + B - 1) / B;
    rem = le % B;
    w = 0;
    s = 32'h1;
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    for (int p = 0; p < num; p++)
      for (int b = 0; b < nb; b++) begin
        if (m == 1) d = {2{s}};
        else for (int i = 0; i < B; i++) d[8*i +: 8] = m == 2 ? 8'hA5 : 8'((w * B + i) % 256);
        exp_d.push_back(d);
        exp_k.push_back((b == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF);
        exp_l.push_back(b == nb - 1);
        w++;
        s = prbs_next(s);
      end
  endtask
  task automatic start_run(input int m, input int len, input int num);
    @(negedge clk);
    test_en = 0; tx_tready = 0; flip = 0;
    mode = 2'(m); pkt_len = 16'(len); pkt_num = 32'(num);
    @(negedge clk);
    test_en = 1;
  endtask
  // Drives tready and records every accepted tx beat until done, a beat budget, or a cycle limit
  task automatic pump(input int pct, input int max_beats, input int drop_at, input int inject_at);
    int n, r;
    bit stalled;
    logic [63:0] hd;
    logic [7:0] hk;
    logic hl;
    n = 0; stalled = 0; hd = 0; hk = 0; hl = 0;
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    stall_viol = 0;
    timed_out = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (test_done || n >= max_beats) begin
        timed_out = 0;
        break;
      end
      if (stalled && (!tx_tvalid || tx_tdata !== hd || tx_tkeep !== hk || tx_tlast !== hl)) stall_viol++;
      r = $urandom_range(0, 99);
      tx_tready = r < pct;
      if (n == drop_at) test_en = 0;
      flip = n == inject_at ? 64'h10 : 64'h0;
      stalled = tx_tvalid && !tx_tready;
      hd = tx_tdata; hk = tx_tkeep; hl = tx_tlast;
      if (tx_tvalid && tx_tready) begin
        obs_d.push_back(tx_tdata); obs_k.push_back(tx_tkeep); obs_l.push_back(tx_tlast);
        n++;
      end
    end
    flip = 0;
  endtask
  task automatic test_reset;
    rstn = 0; test_en = 0; tx_tready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tkeep, tx_tdata, rx_tready, test_done, test_pass} !== 76'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {tx_tvalid, tx_tlast, tx_tkeep, tx_tdata, rx_tready, test_done, test_pass});
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt} !== 96'h0) begin
      failures++;
      $display("FAIL reset_counters got=%h exp=0", {tx_pkt_cnt, rx_pkt_cnt, err_cnt});
    end
    rstn = 1;
    @(negedge clk);
    checks++;
    if ({rx_tready, tx_tvalid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got=%b exp=10", {rx_tready, tx_tvalid});
    end
  endtask
  task automatic test_incr;
    gen_model(0, 64, 4);
    start_run(0, 64, 4);
    @(negedge clk);
    checks++;
    if (tx_tvalid !== 1'b1) begin failures++; $display("FAIL start_latency got=%b exp=1", tx_tvalid); end
    pump(100, 1 << 30, -1, -1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL incr_timeout got=%b exp=0", timed_out); end
    checks++;
    if (obs_d.size() != exp_d.size()) begin failures++; $display("FAIL incr_beats got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        failures++;
        $display("FAIL incr_beat%0d got=%h exp=%h", i, {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
      end
    end
    checks++;
    if (obs_d.size() < 2 || obs_d[0][7:0] !== 8'h00 || obs_d[1][7:0] !== 8'h08) begin
      failures++; $display("FAIL incr_first_bytes got=%h exp=0008", obs_d.size() < 2 ? 16'hx : {obs_d[0][7:0], obs_d[1][7:0]});
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_done, test_pass} !== {32'd4, 32'd4, 32'd0, 2'b11}) begin
      failures++;
      $display("FAIL incr_status got=%0d/%0d/%0d done=%b pass=%b exp=4/4/0 done=1 pass=1", tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_done, test_pass);
    end
  endtask
  task automatic test_fixed;
    gen_model(2, 13, 3);
    junk = 1;
    start_run(2, 13, 3);
    pump(100, 1 << 30, -1, -1);
    junk = 0;
    checks++;
    if (obs_d.size() != exp_d.size() || timed_out) begin
      failures++; $display("FAIL fixed_beats got=%0d exp=%0d timeout=%b", obs_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        failures++;
        $display("FAIL fixed_beat%0d got=%h exp=%h", i, {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
      end
    end
    checks++;
    if (obs_k.size() < 2 || obs_k[1] !== 8'h1F) begin
      failures++; $display("FAIL fixed_last_keep got=%h exp=1f", obs_k.size() < 2 ? 8'hx : obs_k[1]);
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass} !== {32'd3, 32'd3, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL fixed_status got=%0d/%0d/%0d pass=%b exp=3/3/0 pass=1", tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass);
    end
  endtask
  task automatic test_prbs;
    int len, num;
    len = $urandom_range(1, 40);
    num = $urandom_range(2, 5);
    gen_model(1, len, num);
    start_run(1, len, num);
    pump(50, 1 << 30, -1, -1);
    checks++;
    if (obs_d.size() != exp_d.size() || timed_out) begin
      failures++; $display("FAIL prbs_beats len=%0d got=%0d exp=%0d timeout=%b", len, obs_d.size(), exp_d.size(), timed_out);
    end
    checks++;
    if (stall_viol != 0) begin failures++; $display("FAIL prbs_stall_stable got=%0d exp=0", stall_viol); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        failures++;
        $display("FAIL prbs_beat%0d got=%h exp=%h", i, {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
      end
    end
    checks++;
    if (obs_d.size() < 1 || obs_d[0] !== 64'h0000_0001_0000_0001) begin
      failures++; $display("FAIL prbs_first_word got=%h exp=0000000100000001", obs_d.size() < 1 ? 64'hx : obs_d[0]);
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass} !== {32'(num), 32'(num), 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL prbs_status got=%0d/%0d/%0d pass=%b exp=%0d/%0d/0 pass=1", tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass, num, num);
    end
  endtask
  task automatic test_error;
    gen_model(0, 64, 4);
    start_run(0, 64, 4);
    pump(100, 1 << 30, -1, 11);
    checks++;
    if (obs_d.size() != exp_d.size() || timed_out) begin
      failures++; $display("FAIL err_beats got=%0d exp=%0d timeout=%b", obs_d.size(), exp_d.size(), timed_out);
    end
    checks++;
    if (err_cnt !== 32'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", err_cnt); end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, test_done, test_pass} !== {32'd4, 32'd4, 2'b10}) begin
      failures++;
      $display("FAIL err_status got=%0d/%0d done=%b pass=%b exp=4/4 done=1 pass=0", tx_pkt_cnt, rx_pkt_cnt, test_done, test_pass);
    end
  endtask
  task automatic test_stop;
    gen_model(0, 64, 2);
    start_run(0, 64, 0);
    pump(100, 1 << 30, 11, -1);
    checks++;
    if (obs_d.size() != exp_d.size() || timed_out) begin
      failures++; $display("FAIL stop_beats got=%0d exp=%0d timeout=%b", obs_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        failures++;
        $display("FAIL stop_beat%0d got=%h exp=%h", i, {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
      end
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_done, test_pass} !== {32'd2, 32'd2, 32'd0, 2'b11}) begin
      failures++;
      $display("FAIL stop_status got=%0d/%0d/%0d done=%b pass=%b exp=2/2/0 done=1 pass=1", tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_done, test_pass);
    end
  endtask
  task automatic test_reset_mid;
    gen_model(0, 64, 3);
    start_run(0, 64, 3);
    pump(100, 12, -1, -1);
    checks++;
    if ({tx_tvalid, tx_pkt_cnt} !== {1'b1, 32'd1}) begin
      failures++; $display("FAIL mid_pre_reset got=%b/%0d exp=1/1", tx_tvalid, tx_pkt_cnt);
    end
    #1 rstn = 0; test_en = 0;
    #1;
    checks++;
    if (tx_tvalid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", tx_tvalid); end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_done, test_pass} !== 98'h0) begin
      failures++; $display("FAIL mid_counters got=%0d/%0d/%0d exp=0/0/0", tx_pkt_cnt, rx_pkt_cnt, err_cnt);
    end
    @(negedge clk);
    rstn = 1;
    start_run(0, 64, 3);
    pump(100, 1 << 30, -1, -1);
    checks++;
    if (obs_d.size() != exp_d.size() || timed_out) begin
      failures++; $display("FAIL mid_restart_beats got=%0d exp=%0d timeout=%b", obs_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        failures++;
        $display("FAIL mid_restart_beat%0d got=%h exp=%h", i, {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
      end
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass} !== {32'd3, 32'd3, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL mid_restart_status got=%0d/%0d/%0d pass=%b exp=3/3/0 pass=1", tx_pkt_cnt, rx_pkt_cnt, err_cnt, test_pass);
    end
  endtask
  initial begin
    test_reset();
    test_incr();
    test_fixed();
    test_prbs();
    test_error();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
